// File: rtl/cpu_controller.sv
// Instruction register, decoder and control FSM sequencing the Simple RISC Machine datapath.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_COUNT_EN.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [2:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_REG
    } state_t;

    state_t      state_reg;
    logic [15:0] ir_reg;
    logic        err_reg;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_reg[15:13];
    assign op     = ir_reg[12:11];
    assign rn     = ir_reg[10:8];
    assign rd     = ir_reg[7:5];
    assign sh     = ir_reg[4:3];
    assign rm     = ir_reg[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_WAIT;
            ir_reg    <= 16'h0000;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    // The IR only changes while idle, so it is stable for the whole instruction
                    if (load)
                        ir_reg <= in;
                    if (s) begin
                        err_reg   <= 1'b0;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_mov_imm)
                        state_reg <= S_WRITE_IMM;
                    else if (is_mov_reg || is_mvn)
                        state_reg <= S_GET_B;
                    else if (is_alu)
                        state_reg <= S_GET_A;
                    else begin
                        err_reg   <= 1'b1;
                        state_reg <= S_WAIT;
                    end
                end
                S_WRITE_IMM: state_reg <= S_WAIT;
                S_GET_A:     state_reg <= S_GET_B;
                S_GET_B:     state_reg <= S_COMPUTE;
                S_COMPUTE:   state_reg <= is_cmp ? S_WAIT : S_WRITE_REG;
                S_WRITE_REG: state_reg <= S_WAIT;
                default:     state_reg <= S_WAIT;
            endcase
        end
    end

`ifdef CTRL_RETIRE_COUNT_EN
    logic [15:0] retired_reg;
    logic        retire_pulse;

    assign retire_pulse = (state_reg == S_WRITE_IMM) || (state_reg == S_WRITE_REG) ||
                          ((state_reg == S_COMPUTE) && is_cmp);

    always_ff @(posedge clk) begin
        if (reset)
            retired_reg <= 16'h0000;
        else if (retire_pulse)
            retired_reg <= retired_reg + 16'd1;
    end

    assign retired = retired_reg;
`else
    assign retired = 16'h0000;
`endif

    assign w        = (state_reg == S_WAIT);
    assign err      = err_reg;
    assign readnum  = (state_reg == S_GET_A) ? rn : rm;
    assign writenum = is_mov_imm ? rn : rd;
    assign shift    = sh;
    assign ALUop    = is_alu ? op : 2'b00;
    assign sximm8   = {{8{ir_reg[7]}}, ir_reg[7:0]};
    assign sximm5   = {{11{ir_reg[4]}}, ir_reg[4:0]};

    // Strobes are gated by reset so an aborted write never reaches the register file
    always_comb begin
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        write = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        vsel  = 3'b000;
        if (!reset) begin
            case (state_reg)
                S_WRITE_IMM: begin
                    write = 1'b1;
                    vsel  = 3'b011;
                end
                S_GET_A: loada = 1'b1;
                S_GET_B: loadb = 1'b1;
                S_COMPUTE: begin
                    asel  = is_mov_reg;
                    loadc = !is_cmp;
                    loads = is_cmp;
                end
                S_WRITE_REG: begin
                    write = 1'b1;
                    vsel  = 3'b001;
                end
                default: ;
            endcase
        end
    end

endmodule
